if_fetch_unit: RTL and testbench

//   Instruction-fetch front end: producer side of the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch front end feeding the IF/ID pipeline register
//
// Holds the fetch PC and drives a req/ack instruction-memory port.
// Applies branch redirects and pipeline freeze.
// Presents {PC + PC_STEP, instruction} to IF/ID, or a NOP bubble when no
// valid instruction is available.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   freeze                    IF/ID will not load this cycle
//   branch_taken, branch_addr redirect request and target from EX
//   imem_req, imem_addr       memory request and word address
//   imem_ack, imem_rdata      memory data valid (may be same cycle as req) and data
//   PC_IF_stage               fetch address + PC_STEP; 0 when !if_valid
//   Instruction_IF            fetched instruction; NOP_INSTR when !if_valid
//   if_valid                  outputs carry a real instruction
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF_stage,
    output logic [31:0] Instruction_IF,
    output logic        if_valid
);

    // REQ: request outstanding or issuing.
    // HOLD: instruction parked while frozen.
    // SQUASH: draining an access whose data is stale after a redirect.
    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [31:0] next_seq;

    assign next_seq  = req_addr_q + PC_STEP;  // wraps mod 2^32
    assign imem_addr = req_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            req_addr_q   <= RESET_PC;
            redir_addr_q <= RESET_PC;
            inst_buf_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            redir_addr_q <= redir_addr_d;
            inst_buf_q   <= inst_buf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        redir_addr_d   = redir_addr_q;
        inst_buf_d     = inst_buf_q;
        imem_req       = 1'b1;
        if_valid       = 1'b0;
        Instruction_IF = NOP_INSTR;
        PC_IF_stage    = 32'd0;

        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Sequential data is on the wrong path; drop it.
                        req_addr_d = branch_addr;
                    end else begin
                        if_valid       = 1'b1;
                        Instruction_IF = imem_rdata;
                        PC_IF_stage    = next_seq;
                        if (freeze) begin
                            inst_buf_d = imem_rdata;
                            state_d    = S_HOLD;
                        end else begin
                            req_addr_d = next_seq;
                        end
                    end
                end else if (branch_taken) begin
                    // Address must stay stable until ack, so park the target.
                    redir_addr_d = branch_addr;
                    state_d      = S_SQUASH;
                end
            end

            S_HOLD: begin
                imem_req = 1'b0;
                if (branch_taken) begin
                    req_addr_d = branch_addr;
                    state_d    = S_REQ;
                end else begin
                    if_valid       = 1'b1;
                    Instruction_IF = inst_buf_q;
                    PC_IF_stage    = next_seq;
                    if (!freeze) begin
                        req_addr_d = next_seq;
                        state_d    = S_REQ;
                    end
                end
            end

            S_SQUASH: begin
                if (branch_taken) begin
                    redir_addr_d = branch_addr;
                end
                if (imem_ack) begin
                    // Newest redirect wins, including one arriving with the ack.
                    req_addr_d = branch_taken ? branch_addr : redir_addr_q;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - table-driven self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'hE000_0000;
    localparam logic [31:0] A   = 32'hE100_0000;
    localparam logic [31:0] D   = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] PC_IF_stage;
    logic [31:0] Instruction_IF;
    logic        if_valid;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PC_IF_stage    (PC_IF_stage),
        .Instruction_IF (Instruction_IF),
        .if_valid       (if_valid)
    );

    typedef struct {
        logic        fr;
        logic        br;
        logic [31:0] ba;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(logic fr, logic br, logic [31:0] ba, logic ack, logic [31:0] rd,
                                logic e_req, logic [31:0] e_addr, logic e_val,
                                logic [31:0] e_pc, logic [31:0] e_ins);
        vec_t r;
        r.fr = fr; r.br = br; r.ba = ba; r.ack = ack; r.rd = rd;
        r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc; r.e_ins = e_ins;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic e_req, input logic [31:0] e_addr,
                           input logic e_val, input logic [31:0] e_pc, input logic [31:0] e_ins);
        chk("imem_req", row, {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", row, imem_addr, e_addr);
        chk("if_valid", row, {31'd0, if_valid}, {31'd0, e_val});
        chk("PC_IF_stage", row, PC_IF_stage, e_pc);
        chk("Instruction_IF", row, Instruction_IF, e_ins);
    endtask

    initial begin
        // zero-wait sequential fetch
        v.push_back(mk(0, 0, 0, 1, A | 32'h0,  1, 32'h0,  1, 32'h4,  A | 32'h0));
        v.push_back(mk(0, 0, 0, 1, A | 32'h4,  1, 32'h4,  1, 32'h8,  A | 32'h4));
        v.push_back(mk(0, 0, 0, 1, A | 32'h8,  1, 32'h8,  1, 32'hC,  A | 32'h8));
        // two wait states per access
        v.push_back(mk(0, 0, 0, 0, D,          1, 32'hC,  0, 32'h0,  NOP));
        v.push_back(mk(0, 0, 0, 0, D,          1, 32'hC,  0, 32'h0,  NOP));
        v.push_back(mk(0, 0, 0, 1, A | 32'hC,  1, 32'hC,  1, 32'h10, A | 32'hC));
        v.push_back(mk(0, 0, 0, 0, D,          1, 32'h10, 0, 32'h0,  NOP));
        v.push_back(mk(0, 0, 0, 0, D,          1, 32'h10, 0, 32'h0,  NOP));
        v.push_back(mk(0, 0, 0, 1, A | 32'h10, 1, 32'h10, 1, 32'h14, A | 32'h10));
        // branch with ack: data dropped, redirect to 8
        v.push_back(mk(0, 1, 32'h8, 1, A | 32'h14, 1, 32'h14, 0, 32'h0, NOP));
        // freeze on ack of 8 for three cycles, then release
        v.push_back(mk(1, 0, 0, 1, A | 32'h8,  1, 32'h8,  1, 32'hC,  A | 32'h8));
        v.push_back(mk(1, 0, 0, 0, D,          0, 32'h8,  1, 32'hC,  A | 32'h8));
        v.push_back(mk(1, 0, 0, 0, D,          0, 32'h8,  1, 32'hC,  A | 32'h8));
        v.push_back(mk(0, 0, 0, 0, D,          0, 32'h8,  1, 32'hC,  A | 32'h8));
        v.push_back(mk(0, 0, 0, 1, A | 32'hC,  1, 32'hC,  1, 32'h10, A | 32'hC));
        // redirect to 0x20, then branch to 0x100 during its wait -> squash
        v.push_back(mk(0, 1, 32'h20,  1, A | 32'h10, 1, 32'h10, 0, 32'h0, NOP));
        v.push_back(mk(0, 1, 32'h100, 0, D,          1, 32'h20, 0, 32'h0, NOP));
        v.push_back(mk(0, 0, 0,       0, D,          1, 32'h20, 0, 32'h0, NOP));
        v.push_back(mk(0, 0, 0,       1, A | 32'h20, 1, 32'h20, 0, 32'h0, NOP));
        v.push_back(mk(0, 0, 0, 1, A | 32'h100, 1, 32'h100, 1, 32'h104, A | 32'h100));
        // repeated branches while squashing: newest target (with the ack) wins
        v.push_back(mk(0, 1, 32'h200, 0, D,           1, 32'h104, 0, 32'h0, NOP));
        v.push_back(mk(0, 1, 32'h300, 0, D,           1, 32'h104, 0, 32'h0, NOP));
        v.push_back(mk(0, 1, 32'h400, 1, A | 32'h104, 1, 32'h104, 0, 32'h0, NOP));
        v.push_back(mk(0, 0, 0, 1, A | 32'h400, 1, 32'h400, 1, 32'h404, A | 32'h400));
        // HOLD with freeze and branch in the same cycle: branch wins
        v.push_back(mk(1, 0, 0,      1, A | 32'h404, 1, 32'h404, 1, 32'h408, A | 32'h404));
        v.push_back(mk(1, 1, 32'h40, 0, D,           0, 32'h404, 0, 32'h0,   NOP));
        v.push_back(mk(0, 0, 0,      1, A | 32'h40,  1, 32'h40,  1, 32'h44,  A | 32'h40));
        // address wrap at top of memory
        v.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, A | 32'h44, 1, 32'h44, 0, 32'h0, NOP));
        v.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'hFFFF_FFFC));
        v.push_back(mk(0, 0, 0, 1, A | 32'h0,  1, 32'h0,  1, 32'h4,  A | 32'h0));
        // wait on address 4, reset arrives mid-wait below
        v.push_back(mk(0, 0, 0, 0, D,          1, 32'h4,  0, 32'h0,  NOP));

        // reset state
        @(negedge clk);
        chk_all(-1, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < v.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            freeze       = v[i].fr;
            branch_taken = v[i].br;
            branch_addr  = v[i].ba;
            imem_ack     = v[i].ack;
            imem_rdata   = v[i].rd;
            @(negedge clk);
            chk_all(i, v[i].e_req, v[i].e_addr, v[i].e_val, v[i].e_pc, v[i].e_ins);
        end

        // asynchronous reset off the clock edge while waiting on address 4
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_all(100, 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        @(posedge clk);
        #1 rst = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = A;
        @(negedge clk);
        chk_all(101, 1'b1, 32'h0, 1'b1, 32'h4, A);
        @(posedge clk);
        #1 imem_rdata = A | 32'h4;
        @(negedge clk);
        chk_all(102, 1'b1, 32'h4, 1'b1, 32'h8, A | 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
